// File: rtl/sd_data_sequencer.sv
// SD host DATA-path sequencer: latches a transfer request, steps each block
// through FIFO readiness and the physical layer, and supervises per-phase timeouts.
module sd_data_sequencer #(
  parameter int BLOCKS_W  = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 NewData,
  input  logic                 WriteRead,
  input  logic [BLOCKS_W-1:0]  Blocks,
  input  logic                 MultipleData,
  input  logic                 Timeout_enable,
  input  logic [TIMEOUT_W-1:0] Timeout_reg,
  input  logic                 FIFO_ok,
  input  logic                 Serial_ready,
  input  logic                 Complete,
  output logic                 Send,
  output logic                 Idle,
  output logic                 Timeout,
  output logic                 Data_transfer_complete,
  output logic                 Busy,
  output logic                 Dir,
  output logic [BLOCKS_W-1:0]  Blocks_left
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FIFO_WAIT, S_TRANSFER, S_DONE, S_TOUT
  } state_t;

  state_t               state_q;
  logic                 send_q, idle_q, tout_q, dtc_q, busy_q, dir_q;
  logic                 ten_q;
  logic [TIMEOUT_W-1:0] treg_q;
  logic [TIMEOUT_W-1:0] timer_q;
  logic [BLOCKS_W-1:0]  blocks_left_q;

  logic [TIMEOUT_W-1:0] timer_inc;
  logic                 expired;
  logic                 block_start;

  // The phase lasts exactly treg_q cycles: expiry fires when the timer,
  // cleared on phase entry, reaches treg_q-1 at a clock edge.
  assign timer_inc   = (timer_q == '1) ? timer_q : timer_q + TIMEOUT_W'(1);
  assign expired     = ten_q && (treg_q != '0) && (timer_q == treg_q - TIMEOUT_W'(1));
  // A block starts only when FIFO_ok and Serial_ready are both high at the same edge;
  // neither is a held request, so a one-sided high is simply waited out.
  assign block_start = FIFO_ok && Serial_ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      send_q        <= 1'b0;
      idle_q        <= 1'b1;
      tout_q        <= 1'b0;
      dtc_q         <= 1'b0;
      busy_q        <= 1'b0;
      dir_q         <= 1'b0;
      ten_q         <= 1'b0;
      treg_q        <= '0;
      timer_q       <= '0;
      blocks_left_q <= '0;
    end else begin
      send_q <= 1'b0;
      tout_q <= 1'b0;
      dtc_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (NewData) begin
            dir_q         <= WriteRead;
            ten_q         <= Timeout_enable;
            treg_q        <= Timeout_reg;
            blocks_left_q <= MultipleData ? Blocks : BLOCKS_W'(1);
            busy_q        <= 1'b1;
            state_q       <= S_SETUP;
          end
        end
        S_SETUP: begin
          timer_q <= '0;
          if (blocks_left_q == '0) begin
            dtc_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_FIFO_WAIT;
          end
        end
        S_FIFO_WAIT: begin
          if (block_start) begin
            send_q  <= 1'b1;
            idle_q  <= 1'b0;
            timer_q <= '0;
            state_q <= S_TRANSFER;
          end else if (expired) begin
            tout_q  <= 1'b1;
            state_q <= S_TOUT;
          end else begin
            timer_q <= timer_inc;
          end
        end
        S_TRANSFER: begin
          if (Complete) begin
            blocks_left_q <= blocks_left_q - BLOCKS_W'(1);
            idle_q        <= 1'b1;
            timer_q       <= '0;
            if (blocks_left_q == BLOCKS_W'(1)) begin
              dtc_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_FIFO_WAIT;
            end
          end else if (expired) begin
            idle_q  <= 1'b1;
            tout_q  <= 1'b1;
            state_q <= S_TOUT;
          end else begin
            timer_q <= timer_inc;
          end
        end
        S_DONE, S_TOUT: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          idle_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Send                   = send_q;
  assign Idle                   = idle_q;
  assign Timeout                = tout_q;
  assign Data_transfer_complete = dtc_q;
  assign Busy                   = busy_q;
  assign Dir                    = dir_q;
  assign Blocks_left            = blocks_left_q;

endmodule

// File: tb/tb_sd_data_sequencer.sv
// Directed bench for sd_data_sequencer: expected Blocks_left per Send is queued
// at request time and popped when the DUT pulses Send.
module tb_sd_data_sequencer;
  localparam int BW = 8;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          Reset, NewData, WriteRead, MultipleData, Timeout_enable;
  logic [BW-1:0] Blocks;
  logic [TW-1:0] Timeout_reg;
  logic          FIFO_ok, Serial_ready, Complete;
  logic          Send, Idle, Timeout, Data_transfer_complete, Busy, Dir;
  logic [BW-1:0] Blocks_left;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        exp_dir;
  int          cyc, n_sends, t_first_send, t_done, t_tout, t_cmp, cd;
  bit          got_done, got_tout;

  sd_data_sequencer #(.BLOCKS_W(BW), .TIMEOUT_W(TW)) dut (
    .Clock(clk), .Reset(Reset), .NewData(NewData), .WriteRead(WriteRead),
    .Blocks(Blocks), .MultipleData(MultipleData), .Timeout_enable(Timeout_enable),
    .Timeout_reg(Timeout_reg), .FIFO_ok(FIFO_ok), .Serial_ready(Serial_ready),
    .Complete(Complete), .Send(Send), .Idle(Idle), .Timeout(Timeout),
    .Data_transfer_complete(Data_transfer_complete), .Busy(Busy), .Dir(Dir),
    .Blocks_left(Blocks_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue a request, queue the expected Blocks_left per block, then scramble the
  // live config so any use of unlatched inputs shows up.
  task automatic start(input logic dir, input logic [BW-1:0] blk, input logic multi,
                       input logic ten, input logic [TW-1:0] treg);
    int cnt;
    @(negedge clk);
    WriteRead = dir; Blocks = blk; MultipleData = multi;
    Timeout_enable = ten; Timeout_reg = treg; NewData = 1'b1;
    exp_dir = dir;
    cnt = multi ? int'(blk) : 1;
    for (int i = cnt; i >= 1; i--) exp_q.push_back(32'(i));
    cyc = 0; n_sends = 0; got_done = 0; got_tout = 0;
    t_first_send = -1; t_done = -1; t_tout = -1; t_cmp = -100; cd = 0;
    @(negedge clk);
    cyc = 1;
    NewData = 1'b0; WriteRead = ~dir; MultipleData = ~multi;
    Blocks = BW'($urandom_range(1, 255));
    Timeout_enable = 1'b1; Timeout_reg = TW'($urandom_range(1, 3));
  endtask

  // Play the physical layer: Complete five cycles after every Send.
  task automatic run(input int max_cyc, input int stop_sends);
    logic [31:0] e;
    while (!got_done && !got_tout && cyc < max_cyc &&
           !(stop_sends != 0 && n_sends == stop_sends)) begin
      @(negedge clk);
      cyc++;
      Complete = 1'b0;
      if (Send) begin
        n_sends++;
        if (t_first_send < 0) t_first_send = cyc;
        if (exp_q.size() == 0) check("send_extra", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("blocks_left_at_send", 32'(Blocks_left), e);
        end
        check("dir_at_send", 32'(Dir), 32'(exp_dir));
        check("idle_in_transfer", 32'(Idle), 32'd0);
        cd = 5;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          Complete = 1'b1;
          t_cmp = cyc;
        end
      end
      if (Data_transfer_complete) begin
        got_done = 1; t_done = cyc;
        check("blocks_left_at_done", 32'(Blocks_left), 32'd0);
        check("busy_at_done", 32'(Busy), 32'd1);
      end
      if (Timeout) begin
        got_tout = 1; t_tout = cyc;
      end
    end
  endtask

  task automatic check_back_idle(input string tag);
    @(negedge clk);
    check(tag, {30'd0, Busy, Idle}, 32'd1);
  endtask

  initial begin
    Reset = 1'b1; NewData = 1'b0; WriteRead = 1'b0; Blocks = '0; MultipleData = 1'b0;
    Timeout_enable = 1'b0; Timeout_reg = '0; FIFO_ok = 1'b1; Serial_ready = 1'b1;
    Complete = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_idle", 32'(Idle), 32'd1);
    check("reset_pulses", {29'd0, Send, Timeout, Data_transfer_complete}, 32'd0);
    check("reset_busy_dir", {30'd0, Busy, Dir}, 32'd0);
    check("reset_blocks_left", 32'(Blocks_left), 32'd0);
    Reset = 1'b0;

    // single write block
    start(1'b1, 8'd1, 1'b0, 1'b0, 16'd0);
    run(200, 0);
    check("wr1_done", 32'(got_done), 32'd1);
    check("wr1_sends", 32'(n_sends), 32'd1);
    check("wr1_first_send_latency", 32'(t_first_send), 32'd3);
    check("wr1_done_after_complete", 32'(t_done), 32'(t_cmp + 1));
    check_back_idle("wr1_back_idle");

    // three-block read
    start(1'b0, 8'd3, 1'b1, 1'b0, 16'd0);
    run(300, 0);
    check("rd3_done", 32'(got_done), 32'd1);
    check("rd3_sends", 32'(n_sends), 32'd3);
    check("rd3_done_after_complete", 32'(t_done), 32'(t_cmp + 1));
    check("rd3_queue_drained", 32'(exp_q.size()), 32'd0);
    check_back_idle("rd3_back_idle");

    // MultipleData=0 forces a single block
    start(1'b1, 8'd5, 1'b0, 1'b0, 16'd0);
    run(200, 0);
    check("single_sends", 32'(n_sends), 32'd1);
    check("single_done", 32'(got_done), 32'd1);
    check_back_idle("single_back_idle");

    // zero-length transfer
    start(1'b0, 8'd0, 1'b1, 1'b0, 16'd0);
    run(50, 0);
    check("zero_sends", 32'(n_sends), 32'd0);
    check("zero_done_latency", 32'(t_done), 32'd2);
    check_back_idle("zero_back_idle");

    // timeout in FIFO_WAIT after exactly 70 cycles
    FIFO_ok = 1'b0;
    start(1'b1, 8'd1, 1'b0, 1'b1, 16'd70);
    run(300, 0);
    check("tout_fired", 32'(got_tout), 32'd1);
    check("tout_latency", 32'(t_tout), 32'd72);
    check("tout_blocks_left", 32'(Blocks_left), 32'd1);
    check("tout_no_done", 32'(got_done), 32'd0);
    @(negedge clk);
    check("tout_single_pulse", 32'(Timeout), 32'd0);
    check("tout_back_idle", {30'd0, Busy, Idle}, 32'd1);
    exp_q.delete();

    // supervision disabled: no timeout in 200 cycles, then finish normally
    start(1'b1, 8'd1, 1'b0, 1'b0, 16'd70);
    run(200, 0);
    check("notout_none", 32'(got_tout), 32'd0);
    check("notout_still_busy", 32'(Busy), 32'd1);
    FIFO_ok = 1'b1;
    run(400, 0);
    check("notout_done", 32'(got_done), 32'd1);
    check("notout_sends", 32'(n_sends), 32'd1);
    check_back_idle("notout_back_idle");

    // reset two cycles after Send of block 2 of 4
    start(1'b1, 8'd4, 1'b1, 1'b0, 16'd0);
    run(400, 2);
    check("rst_sends_before", 32'(n_sends), 32'd2);
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b1;
    @(negedge clk);
    check("rst_outputs", {25'd0, Idle, Send, Timeout, Data_transfer_complete, Busy, Dir, 1'b0},
          32'h40);
    check("rst_blocks_left", 32'(Blocks_left), 32'd0);
    Reset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_quiet", {28'd0, Send, Timeout, Data_transfer_complete, Busy}, 32'd0);
    end
    start(1'b0, 8'd2, 1'b1, 1'b0, 16'd0);
    run(300, 0);
    check("post_rst_sends", 32'(n_sends), 32'd2);
    check("post_rst_done", 32'(got_done), 32'd1);
    check_back_idle("post_rst_back_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
